// File: rtl/shift_pkg.sv
// Shared shift-mode encoding for the pipelined shifter and the ALU decoder.
package shift_pkg;

  typedef enum logic [1:0] {
    SHIFT_SLL = 2'b00,
    SHIFT_SRL = 2'b01,
    SHIFT_SRA = 2'b10,
    SHIFT_ROL = 2'b11
  } shift_mode_t;

endpackage

// File: rtl/shift_stage.sv
// One pipeline level of the barrel shifter: conditional shift by 2**K plus
// the stage's valid/data/shamt/mode/overflow registers with load enable.
module shift_stage
  import shift_pkg::*;
#(
  parameter int unsigned N = 32,
  parameter int unsigned K = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 d_valid,
  input  logic [N-1:0]         d_data,
  input  logic [$clog2(N)-1:0] d_shamt,
  input  shift_mode_t          d_mode,
  input  logic                 d_ovf,
  output logic                 q_valid,
  output logic [N-1:0]         q_data,
  output logic [$clog2(N)-1:0] q_shamt,
  output shift_mode_t          q_mode,
  output logic                 q_ovf
);

  localparam int unsigned D = 1 << K;

  logic [N-1:0] nxt_data;
  logic         nxt_ovf;

  // SRA fill comes from the current MSB, which every earlier SRA level preserved.
  always_comb begin
    nxt_data = d_data;
    nxt_ovf  = d_ovf;
    if (d_shamt[K]) begin
      case (d_mode)
        SHIFT_SLL: begin
          nxt_data = {d_data[N-1-D:0], {D{1'b0}}};
          nxt_ovf  = d_ovf | (|d_data[N-1 -: D]);
        end
        SHIFT_SRL: nxt_data = {{D{1'b0}}, d_data[N-1:D]};
        SHIFT_SRA: nxt_data = {{D{d_data[N-1]}}, d_data[N-1:D]};
        SHIFT_ROL: nxt_data = {d_data[N-1-D:0], d_data[N-1 -: D]};
        default:   nxt_data = d_data;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_valid <= 1'b0;
      q_data  <= '0;
      q_shamt <= '0;
      q_mode  <= SHIFT_SLL;
      q_ovf   <= 1'b0;
    end else if (load) begin
      q_valid <= d_valid;
      q_data  <= nxt_data;
      q_shamt <= d_shamt;
      q_mode  <= d_mode;
      q_ovf   <= nxt_ovf;
    end
  end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter: S registered mux levels (LSB level first) with a
// valid/ready handshake and full backpressure.
module pipelined_shifter
  import shift_pkg::*;
#(
  parameter int unsigned N = 32,
  parameter int unsigned S = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic [N-1:0] in,
  input  logic [S-1:0] shamt,
  input  logic [1:0]   mode,
  output logic         o_valid,
  input  logic         o_ready,
  output logic [N-1:0] out,
  output logic         overflow
);

  // Index 0 is the upstream port, index k+1 is the register of stage k.
  logic        v  [S+1];
  logic [N-1:0] d [S+1];
  logic [S-1:0] sh[S+1];
  shift_mode_t md [S+1];
  logic        ov [S+1];
  logic [S:0]  ld;

  assign v[0]  = i_valid;
  assign d[0]  = in;
  assign sh[0] = shamt;
  assign md[0] = shift_mode_t'(mode);
  assign ov[0] = 1'b0;

  // ld[k] is stage k's load enable; ld[S] stands for the downstream sink.
  always_comb begin
    ld    = '0;
    ld[S] = o_ready;
    for (int unsigned i = 0; i < S; i++) begin
      ld[S-1-i] = !v[S-i] || ld[S-i];
    end
  end

  for (genvar k = 0; k < S; k++) begin : g_stage
    shift_stage #(
      .N(N),
      .K(k)
    ) u_stage (
      .clk    (clk),
      .rst    (rst),
      .load   (ld[k]),
      .d_valid(v[k]),
      .d_data (d[k]),
      .d_shamt(sh[k]),
      .d_mode (md[k]),
      .d_ovf  (ov[k]),
      .q_valid(v[k+1]),
      .q_data (d[k+1]),
      .q_shamt(sh[k+1]),
      .q_mode (md[k+1]),
      .q_ovf  (ov[k+1])
    );
  end

  assign i_ready  = ld[0];
  assign o_valid  = v[S];
  assign out      = d[S];
  assign overflow = ov[S];

endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed and randomised checks of pipelined_shifter (N=32) via an expected-result queue.
module tb_pipelined_shifter;
  import shift_pkg::*;

  localparam int unsigned N = 32;
  localparam int unsigned S = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid;
  logic          i_ready;
  logic [N-1:0]  in;
  logic [S-1:0]  shamt;
  logic [1:0]    mode;
  logic          o_valid;
  logic          o_ready;
  logic [N-1:0]  out;
  logic          overflow;

  pipelined_shifter #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .in      (in),
    .shamt   (shamt),
    .mode    (mode),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .out     (out),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] o;
    logic         v;
  } exp_t;

  exp_t q[$];
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   n_extra = 0;
  int   waits   = 0;
  int   ordy_mode = 1;   // 0: hold low, 1: hold high, 2: random

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [N:0] model(input logic [N-1:0] a, input logic [S-1:0] s,
                                       input logic [1:0] m);
    logic [N-1:0] r;
    logic         f;
    logic [5:0]   inv;
    inv = 6'd32 - {1'b0, s};
    f   = 1'b0;
    case (m)
      2'b00: begin
        r = a << s;
        f = (s != 0) && (|(a >> inv));
      end
      2'b01:   r = a >> s;
      2'b10:   r = $signed(a) >>> s;
      default: r = (a << s) | ((s == 0) ? '0 : (a >> inv));
    endcase
    return {f, r};
  endfunction

  // Downstream ready driver: sole writer of o_ready, changes just after posedge.
  initial begin
    o_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ordy_mode)
        0:       o_ready = 1'b0;
        1:       o_ready = 1'b1;
        default: o_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Output monitor: scoreboard pop on transfer, stability check across stalls.
  logic         hold_v = 1'b0;
  logic [N-1:0] hold_out;
  logic         hold_ovf;
  exp_t         e;
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && o_valid) begin
        check("hold_out", out, hold_out);
        check("hold_ovf", overflow, hold_ovf);
      end
      if (o_valid && o_ready) begin
        if (q.size() == 0) n_extra++;
        else begin
          e = q.pop_front();
          check("out", out, e.o);
          check("ovf", overflow, e.v);
        end
      end
      hold_v   = o_valid && !o_ready;
      hold_out = out;
      hold_ovf = overflow;
    end
  end

  task automatic send(input logic [N-1:0] a, input logic [S-1:0] s, input logic [1:0] m,
                      input logic [N-1:0] eo, input logic eov);
    int tries;
    i_valid = 1'b1;
    in      = a;
    shamt   = s;
    mode    = m;
    tries   = 0;
    @(negedge clk);
    while (!i_ready && tries < 100) begin
      waits++;
      tries++;
      @(negedge clk);
    end
    if (!i_ready) begin
      check("accept_timeout", i_ready, 1'b1);
      $fatal(1, "accept never happened");
    end
    @(posedge clk);
    q.push_back('{eo, eov});
    #1;
    i_valid = 1'b0;
  endtask

  task automatic drain(output int cnt);
    cnt = 0;
    while (q.size() != 0 && cnt < 300) begin
      @(posedge clk);
      #2;
      cnt++;
    end
  endtask

  typedef struct {
    logic [N-1:0] a;
    logic [S-1:0] s;
    logic [1:0]   m;
    logic [N-1:0] eo;
    logic         ev;
  } vec_t;

  vec_t bp_tab[10] = '{
    '{32'h0000_00FF, 5'd4,  2'b00, 32'h0000_0FF0, 1'b0},
    '{32'hF000_0000, 5'd8,  2'b01, 32'h00F0_0000, 1'b0},
    '{32'hF000_0000, 5'd8,  2'b10, 32'hFFF0_0000, 1'b0},
    '{32'h1234_5678, 5'd8,  2'b11, 32'h3456_7812, 1'b0},
    '{32'hFFFF_FFFF, 5'd16, 2'b00, 32'hFFFF_0000, 1'b1},
    '{32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001, 1'b0},
    '{32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF, 1'b0},
    '{32'h0000_000F, 5'd30, 2'b11, 32'hC000_0003, 1'b0},
    '{32'h0000_0003, 5'd31, 2'b00, 32'h8000_0000, 1'b1},
    '{32'h1234_5678, 5'd0,  2'b00, 32'h1234_5678, 1'b0}
  };

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int idx;
    int nstale;
    logic acc;
    logic [N:0] r;
    logic [N-1:0] ra;
    logic [S-1:0] rs;
    logic [1:0]   rm;

    rst = 1'b1; i_valid = 1'b0; in = '0; shamt = '0; mode = 2'b00;
    #3;
    check("rst_ovalid", o_valid, 1'b0);
    check("rst_out", out, 32'h0);
    check("rst_ovf", overflow, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 check("rst_iready", i_ready, 1'b1);

    // Latency: count edges from the accepting one until o_valid shows.
    send(32'h0000_0001, 5'd31, SHIFT_SLL, 32'h8000_0000, 1'b0);
    cnt = 1;
    while (!o_valid && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("latency", cnt, 5);
    drain(cnt);

    send(32'hC000_0000, 5'd1, SHIFT_SLL, 32'h8000_0000, 1'b1);
    send(32'h8000_0000, 5'd4, SHIFT_SRA, 32'hF800_0000, 1'b0);
    send(32'h8000_0000, 5'd4, SHIFT_SRL, 32'h0800_0000, 1'b0);
    send(32'h7FFF_FFFF, 5'd31, SHIFT_SRA, 32'h0000_0000, 1'b0);
    send(32'h8000_0001, 5'd1, SHIFT_ROL, 32'h0000_0003, 1'b0);
    send(32'h8000_0001, 5'd0, SHIFT_ROL, 32'h8000_0001, 1'b0);
    drain(cnt);
    check("dir_drain", q.size(), 0);

    // Back-to-back stream with o_ready held high.
    waits = 0;
    for (int i = 0; i < 32; i++) begin
      send(32'h1, i[4:0], SHIFT_SLL, 32'h1 << i, 1'b0);
    end
    check("b2b_stall", waits, 0);
    drain(cnt);
    check("b2b_drain", cnt, 5);

    // Backpressure: downstream stalled for 10 cycles while upstream keeps offering.
    ordy_mode = 0;
    @(posedge clk);
    #1;
    idx = 0;
    repeat (10) begin
      i_valid = 1'b1;
      in      = bp_tab[idx].a;
      shamt   = bp_tab[idx].s;
      mode    = bp_tab[idx].m;
      @(negedge clk);
      acc = i_ready;
      @(posedge clk);
      if (acc) begin
        q.push_back('{bp_tab[idx].eo, bp_tab[idx].ev});
        idx++;
      end
      #1;
    end
    i_valid = 1'b0;
    check("bp_accepted", idx, 5);
    check("bp_iready", i_ready, 1'b0);
    check("bp_ovalid", o_valid, 1'b1);
    ordy_mode = 1;
    while (idx < 10) begin
      send(bp_tab[idx].a, bp_tab[idx].s, bp_tab[idx].m, bp_tab[idx].eo, bp_tab[idx].ev);
      idx++;
    end
    drain(cnt);
    check("bp_drain", q.size(), 0);

    // Random regression against the operator-based model with random stalls.
    ordy_mode = 2;
    for (int i = 0; i < 200; i++) begin
      ra = $urandom;
      rs = 5'($urandom_range(0, 31));
      rm = 2'($urandom_range(0, 3));
      r  = model(ra, rs, rm);
      send(ra, rs, rm, r[N-1:0], r[N]);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    ordy_mode = 1;
    drain(cnt);
    check("rnd_drain", q.size(), 0);

    // Asynchronous reset with three operations in flight.
    send(32'h0000_00F0, 5'd2, SHIFT_SLL, 32'h0000_03C0, 1'b0);
    send(32'h0000_00F0, 5'd2, SHIFT_SRL, 32'h0000_003C, 1'b0);
    send(32'h0000_00F0, 5'd2, SHIFT_ROL, 32'h0000_03C0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    check("prerst_ovalid", o_valid, 1'b1);
    rst = 1'b1;
    q.delete();
    #1;
    check("arst_ovalid", o_valid, 1'b0);
    check("arst_out", out, 32'h0);
    check("arst_ovf", overflow, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    nstale = 0;
    repeat (12) begin
      @(negedge clk);
      if (o_valid) nstale++;
    end
    check("stale_results", nstale, 0);
    check("extra_results", n_extra, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
